instr_encoder_loader: RTL
=========================

Name: instr_encoder_loader

Overview:
- Encoder counterpart of the single-cycle control unit decoder: takes symbolic instruction requests (kind plus register and immediate fields) and builds 32-bit MIPS words (op, rs, rt, rd, shamt, funct / imm16).
- Writes encoded words sequentially into instruction memory, so benches and the boot path can load programs without hand-assembled hex.
- Sits between a program source (bench or host loader) and the instruction memory write port.

Parameters:
- ADDR_W, 8, instruction memory byte-address width.
- DEPTH, 64, maximum number of words loaded per session (DEPTH*4 <= 2**ADDR_W).
- BASE_ADDR, 0, byte address of the first word; multiple of 4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse: begin a load session at BASE_ADDR.
- finish  in  1  one-cycle pulse: end the session early.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_kind  in  4  0=ADD, 1=SUB, 2=AND, 3=OR, 4=SLT, 5=LW, 6=SW, 7=BEQ, 8=ADDI; 9-15 illegal.
- in_rs  in  5  rs field.
- in_rt  in  5  rt field.
- in_rd  in  5  rd field (R-type only).
- in_imm  in  16  immediate / offset (I-type only).
- mem_we  out  1  instruction memory write enable.
- mem_addr  out  ADDR_W  byte address of write.
- mem_wdata  out  32  encoded instruction.
- count  out  $clog2(DEPTH+1)  words written this session.
- full  out  1  count == DEPTH.
- busy  out  1  session active or write pending.
- err_illegal  out  1  sticky: an illegal kind was accepted this session.

Behaviour:
- Reset (async): state=IDLE, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, full=0, busy=0, err_illegal=0, in_ready=0.
- States:
  - IDLE: in_ready=0. start goes to LOAD; mem_addr, count and err_illegal are cleared to BASE_ADDR/0/0.
  - LOAD: in_ready = !full. Each legal accept registers the encoded word. finish goes to DRAIN. Reaching count==DEPTH goes to DRAIN.
  - DRAIN: in_ready=0. The pending write, if any, completes, then the block returns to IDLE. busy=0 only in IDLE with no pending write.
- Latency: a request accepted at edge N gives mem_we=1 for exactly the cycle after edge N, with mem_addr and mem_wdata valid. Back-to-back accepts give one write per cycle with no bubbles. The memory port has no backpressure.
- Address and count:
  - Write address = BASE_ADDR + 4*count at accept time.
  - count increments on each legal accept.
  - mem_addr is held after the last write.
  - The address never wraps within a session because DEPTH bounds it.
- Encoding:
  - R-type (kinds 0-4): op=000000, shamt=0. funct: ADD=100000, SUB=100010, AND=100100, OR=100101, SLT=101010. Word = {op,rs,rt,rd,shamt,funct}.
  - I-type, word = {op,rs,rt,imm}: LW op=100011, SW op=101011, BEQ op=000100, ADDI op=001000. in_rd is ignored.
- Illegal kind:
  - The request is consumed (ready honoured) but no write occurs and count is unchanged.
  - err_illegal is set and stays set until the next start.
- Simultaneous events:
  - start in LOAD or DRAIN is ignored.
  - finish in the same cycle as an accept: the accepted word is still written, then the block goes to DRAIN.
  - start and finish together in IDLE: start wins and finish is ignored.
  - An accept that makes count==DEPTH drops in_ready in the following cycle, and full rises together with that count.
- Reset mid-operation: the pending write is aborted (mem_we drops immediately) and all reset values apply.

Test Plan:
- Reset, start, one ADD with rs=1, rt=2, rd=3 -> next cycle mem_we=1, mem_addr=0x00, mem_wdata=0x00221820; count=1.
- Back-to-back LW (rs=0, rt=8, imm=0x0004), SW (rs=0, rt=8, imm=0x0008), BEQ (rs=8, rt=9, imm=0xFFFE) -> consecutive writes 0x8C080004@0x00, 0xAC080008@0x04, 0x1109FFFE@0x08; no gaps.
- kind=12 mid-stream between two ADDI -> err_illegal=1, only 2 writes at 0x00 and 0x04, count=2; the next start clears err_illegal.
- DEPTH=4, continuous in_valid -> exactly 4 writes, full=1 and in_ready=0 after the 4th accept, DRAIN then IDLE, busy=0.
- finish asserted on the same cycle as an accepted SLT (rs=4, rt=5, rd=6, mem_wdata=0x0085302A) -> write still occurs, in_ready=0 afterwards.
- Assert reset asynchronously while mem_we=1 -> mem_we, count and busy go to 0 before the next clk edge.

Source files
------------

// File: rtl/instr_encoder_loader_if.sv
// Request-side and memory-write-side signals of the instruction encoder/loader.
// The slave modport is the loader; the master modport is the program source plus the memory port.
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_kind;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [15:0]       in_imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport slave (
        input  in_valid, in_kind, in_rs, in_rt, in_rd, in_imm,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output in_valid, in_kind, in_rs, in_rt, in_rd, in_imm,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Turns symbolic instruction requests into 32-bit MIPS words and writes them
// sequentially into instruction memory starting at BASE_ADDR.
module instr_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 64,
    parameter int BASE_ADDR = 0,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          finish,
    instr_encoder_loader_if.slave         bus,
    output logic [CW-1:0]                 count,
    output logic                          full,
    output logic                          busy,
    output logic                          err_illegal
);
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [CW-1:0]     LAST = CW'(DEPTH);

    state_t      state;
    logic        legal;
    logic        is_rtype;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] enc;
    logic        accept;
    logic [CW-1:0] count_nxt;

    always_comb begin
        legal    = 1'b1;
        is_rtype = 1'b0;
        op       = 6'h00;
        funct    = 6'h00;
        case (bus.in_kind)
            4'd0: begin is_rtype = 1'b1; funct = 6'h20; end
            4'd1: begin is_rtype = 1'b1; funct = 6'h22; end
            4'd2: begin is_rtype = 1'b1; funct = 6'h24; end
            4'd3: begin is_rtype = 1'b1; funct = 6'h25; end
            4'd4: begin is_rtype = 1'b1; funct = 6'h2A; end
            4'd5: op = 6'h23;
            4'd6: op = 6'h2B;
            4'd7: op = 6'h04;
            4'd8: op = 6'h08;
            default: legal = 1'b0;
        endcase
        if (is_rtype)
            enc = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, funct};
        else
            enc = {op, bus.in_rs, bus.in_rt, bus.in_imm};
    end

    assign accept    = (state == LOAD) && bus.in_valid && bus.in_ready;
    assign count_nxt = count + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= BASE;
            bus.mem_wdata <= 32'h0;
            bus.in_ready  <= 1'b0;
            count         <= '0;
            full          <= 1'b0;
            busy          <= 1'b0;
            err_illegal   <= 1'b0;
        end else begin
            bus.mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    // start takes priority over a coincident finish
                    if (start) begin
                        state        <= LOAD;
                        bus.mem_addr <= BASE;
                        bus.in_ready <= 1'b1;
                        count        <= '0;
                        full         <= 1'b0;
                        err_illegal  <= 1'b0;
                        busy         <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept && legal) begin
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= BASE + (ADDR_W'(count) << 2);
                        bus.mem_wdata <= enc;
                        count         <= count_nxt;
                        full          <= (count_nxt == LAST);
                    end
                    if (accept && !legal)
                        err_illegal <= 1'b1;
                    if (finish || (accept && legal && count_nxt == LAST)) begin
                        state        <= DRAIN;
                        bus.in_ready <= 1'b0;
                    end else begin
                        bus.in_ready <= 1'b1;
                    end
                end
                DRAIN: begin
                    // the pending write (if any) is on the port this cycle
                    state        <= IDLE;
                    bus.in_ready <= 1'b0;
                    busy         <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    bus.in_ready <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end
endmodule
